// File: rtl/powlib_sfifo_ex.sv
// rtl/powlib_sfifo_ex.sv - single-clock valid/ready FIFO with exact count, threshold flags, flush and optional output register
module powlib_sfifo_ex #(
  parameter int W    = 16,
  parameter int D    = 8,
  parameter int NFT  = 6,
  parameter int NET  = 1,
  parameter int ERO  = 0,
  parameter int EDBG = 0,
  parameter     ID   = "SFIFOEX"
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic [W-1:0]                 wrdata,
  input  logic                         wrvld,
  output logic                         wrrdy,
  output logic                         wrnf,
  output logic [W-1:0]                 rddata,
  output logic                         rdvld,
  input  logic                         rdrdy,
  output logic                         rdne,
  output logic [$clog2(D+ERO+1)-1:0]   cnt
);

  localparam int C  = D + ERO;
  localparam int CW = $clog2(D + ERO + 1);
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] CMAX  = CW'(C);
  localparam logic [PW-1:0] PLAST = PW'(D - 1);

  if (D < 2 || NFT < 1 || NFT > C || NET < 0 || NET >= C) begin : g_bad_param
    $fatal(1, "%s: illegal parameters D=%0d NFT=%0d NET=%0d ERO=%0d", ID, D, NFT, NET, ERO);
  end

  logic [W-1:0]  mem_q [D];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrnf_q, rdne_q;
  logic          wrinc, rdinc, arr_rd;
  logic [W-1:0]  arr_rdata;

  // Full/empty is derived from the occupancy count only, so D need not be a power of two.
  assign wrrdy     = (cnt_q != CMAX);
  assign wrinc     = wrvld & wrrdy;
  assign rdinc     = rdvld & rdrdy;
  assign arr_rdata = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wrinc)
        wptr_d = (wptr_q == PLAST) ? '0 : wptr_q + 1'b1;
      if (arr_rd)
        rptr_d = (rptr_q == PLAST) ? '0 : rptr_q + 1'b1;
      if (wrinc && !rdinc)
        cnt_d = cnt_q + 1'b1;
      else if (rdinc && !wrinc)
        cnt_d = cnt_q - 1'b1;
    end
  end

  // Flags are registered from the next count so they line up with cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      wrnf_q <= (NFT == 0);
      rdne_q <= 1'b1;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      wrnf_q <= (cnt_d >= CW'(NFT));
      rdne_q <= (cnt_d <= CW'(NET));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clr && wrinc)
      mem_q[wptr_q] <= wrdata;
  end

  if (ERO != 0) begin : g_oreg
    logic         ovld_q, ovld_d, load;
    logic [W-1:0] odata_q;

    // Refill whenever the output slot is empty or leaving and the array holds something.
    always_comb begin
      load   = (cnt_q != CW'(ovld_q)) && (!ovld_q || rdrdy) && !clr;
      ovld_d = ovld_q;
      if (clr)
        ovld_d = 1'b0;
      else if (load)
        ovld_d = 1'b1;
      else if (rdrdy)
        ovld_d = 1'b0;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ovld_q  <= 1'b0;
        odata_q <= '0;
      end else begin
        ovld_q <= ovld_d;
        if (load)
          odata_q <= arr_rdata;
      end
    end

    assign arr_rd = load;
    assign rdvld  = ovld_q;
    assign rddata = odata_q;
  end else begin : g_comb
    assign arr_rd = rdinc;
    assign rdvld  = (cnt_q != '0);
    assign rddata = arr_rdata;
  end

`ifndef SYNTHESIS
  if (EDBG != 0) begin : g_dbg
    always_ff @(posedge clk) begin
      if (!rst && clr)
        $display("%s: flush", ID);
      else if (!rst) begin
        if (wrinc) $display("%s: write %0h cnt=%0d", ID, wrdata, cnt_q);
        if (rdinc) $display("%s: read %0h cnt=%0d", ID, rddata, cnt_q);
      end
    end
  end
`endif

  assign cnt  = cnt_q;
  assign wrnf = wrnf_q;
  assign rdne = rdne_q;

endmodule

// File: tb/tb_powlib_sfifo_ex.sv
// tb/tb_powlib_sfifo_ex.sv - scoreboard bench for powlib_sfifo_ex (D=5 combinational read, D=4 registered output)
module tb_powlib_sfifo_ex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       a_rst, a_clr, a_wrvld, a_rdrdy, a_wrrdy, a_wrnf, a_rdvld, a_rdne;
  logic [7:0] a_wrdata, a_rddata;
  logic [2:0] a_cnt;
  logic       b_rst, b_clr, b_wrvld, b_rdrdy, b_wrrdy, b_wrnf, b_rdvld, b_rdne;
  logic [7:0] b_wrdata, b_rddata;
  logic [2:0] b_cnt;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int a_reads = 0;
  int b_reads = 0;

  powlib_sfifo_ex #(.W(8), .D(5), .NFT(4), .NET(1), .ERO(0), .EDBG(0), .ID("DUTA")) u_a (
    .clk(clk), .rst(a_rst), .clr(a_clr), .wrdata(a_wrdata), .wrvld(a_wrvld), .wrrdy(a_wrrdy),
    .wrnf(a_wrnf), .rddata(a_rddata), .rdvld(a_rdvld), .rdrdy(a_rdrdy), .rdne(a_rdne), .cnt(a_cnt)
  );

  powlib_sfifo_ex #(.W(8), .D(4), .NFT(4), .NET(1), .ERO(1), .EDBG(0), .ID("DUTB")) u_b (
    .clk(clk), .rst(b_rst), .clr(b_clr), .wrdata(b_wrdata), .wrvld(b_wrvld), .wrrdy(b_wrrdy),
    .wrnf(b_wrnf), .rddata(b_rddata), .rdvld(b_rdvld), .rdrdy(b_rdrdy), .rdne(b_rdne), .cnt(b_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every accepted read and bounds occupancy.
  always @(negedge clk) begin
    if (!a_rst) begin
      chk("a_cnt_le_cap", 32'(a_cnt <= 3'd5), 32'd1);
      if (a_rdvld && a_rdrdy && !a_clr) begin
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL a_read: got %0h with nothing expected", a_rddata);
        end else
          chk("a_rddata", 32'(a_rddata), 32'(qa.pop_front()));
        a_reads++;
      end
    end
    if (!b_rst) begin
      chk("b_cnt_le_cap", 32'(b_cnt <= 3'd5), 32'd1);
      if (b_rdvld && b_rdrdy && !b_clr) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL b_read: got %0h with nothing expected", b_rddata);
        end else
          chk("b_rddata", 32'(b_rddata), 32'(qb.pop_front()));
        b_reads++;
      end
    end
  end

  initial begin
    int nxt, rd0, n;
    a_rst = 1; a_clr = 0; a_wrvld = 0; a_rdrdy = 0; a_wrdata = 0;
    b_rst = 1; b_clr = 0; b_wrvld = 0; b_rdrdy = 0; b_wrdata = 0;
    tick; tick;
    a_rst = 0; b_rst = 0;

    chk("a_rst_wrrdy", 32'(a_wrrdy), 32'd1);
    chk("a_rst_rdvld", 32'(a_rdvld), 32'd0);
    chk("a_rst_cnt",   32'(a_cnt),   32'd0);
    chk("a_rst_wrnf",  32'(a_wrnf),  32'd0);
    chk("a_rst_rdne",  32'(a_rdne),  32'd1);
    chk("b_rst_rddata", 32'(b_rddata), 32'd0);

    // Fill D=5 with 0x11..0x15
    for (int i = 0; i < 5; i++) begin
      a_wrvld = 1; a_wrdata = 8'h11 + 8'(i); qa.push_back(a_wrdata);
      tick;
      chk("a_fill_cnt",  32'(a_cnt),  32'(i + 1));
      chk("a_fill_wrnf", 32'(a_wrnf), 32'((i + 1) >= 4));
      chk("a_fill_rdne", 32'(a_rdne), 32'((i + 1) <= 1));
      chk("a_fill_rdvld", 32'(a_rdvld), 32'd1);
    end
    a_wrvld = 0;
    chk("a_full_wrrdy", 32'(a_wrrdy), 32'd0);

    a_rdrdy = 1;
    for (int i = 0; i < 5; i++) tick;
    a_rdrdy = 0;
    chk("a_drain_rdvld", 32'(a_rdvld), 32'd0);
    chk("a_drain_rdne",  32'(a_rdne),  32'd1);
    chk("a_drain_cnt",   32'(a_cnt),   32'd0);

    // Full with simultaneous read: write refused, accepted next cycle
    for (int i = 0; i < 5; i++) begin
      a_wrvld = 1; a_wrdata = 8'h21 + 8'(i); qa.push_back(a_wrdata);
      tick;
    end
    a_wrdata = 8'h26; a_rdrdy = 1;
    tick;
    chk("a_fullrd_cnt",   32'(a_cnt),   32'd4);
    chk("a_fullrd_wrrdy", 32'(a_wrrdy), 32'd1);
    a_rdrdy = 0; qa.push_back(8'h26);
    tick;
    a_wrvld = 0;
    chk("a_refill_cnt", 32'(a_cnt), 32'd5);
    a_rdrdy = 1;
    for (int i = 0; i < 5; i++) tick;
    a_rdrdy = 0;
    chk("a_fullrd_end_cnt", 32'(a_cnt), 32'd0);

    // Wrap-around stream of 0..22 with rdrdy toggling
    nxt = 0; rd0 = a_reads;
    for (int cyc = 0; cyc < 300 && (a_reads - rd0) < 23; cyc++) begin
      a_wrvld = (nxt < 23); a_wrdata = 8'(nxt); a_rdrdy = (cyc % 2 == 0);
      if (a_wrvld && a_wrrdy) begin qa.push_back(8'(nxt)); nxt++; end
      tick;
    end
    a_wrvld = 0; a_rdrdy = 0;
    chk("a_wrap_reads",  32'(a_reads - rd0), 32'd23);
    chk("a_wrap_writes", 32'(nxt), 32'd23);

    // Flush takes priority over a same-cycle write and read
    for (int i = 0; i < 3; i++) begin
      a_wrvld = 1; a_wrdata = 8'h31 + 8'(i); qa.push_back(a_wrdata);
      tick;
    end
    chk("a_pre_clr_cnt", 32'(a_cnt), 32'd3);
    a_clr = 1; a_wrvld = 1; a_wrdata = 8'h99; a_rdrdy = 1; qa.delete();
    tick;
    a_clr = 0; a_wrvld = 0; a_rdrdy = 0;
    chk("a_clr_cnt",   32'(a_cnt),   32'd0);
    chk("a_clr_rdvld", 32'(a_rdvld), 32'd0);
    chk("a_clr_rdne",  32'(a_rdne),  32'd1);
    chk("a_clr_wrrdy", 32'(a_wrrdy), 32'd1);
    a_wrvld = 1; a_wrdata = 8'h3C; qa.push_back(8'h3C);
    tick;
    a_wrvld = 0;
    chk("a_post_clr_data", 32'(a_rddata), 32'h3C);
    a_rdrdy = 1; tick; a_rdrdy = 0;
    chk("a_post_clr_empty", 32'(a_rdvld), 32'd0);

    // Reset mid-stream
    for (int i = 0; i < 4; i++) begin
      a_wrvld = 1; a_wrdata = 8'h41 + 8'(i); qa.push_back(a_wrdata);
      tick;
    end
    chk("a_pre_rst_cnt", 32'(a_cnt), 32'd4);
    a_rst = 1; a_wrdata = 8'h45; qa.delete();
    tick;
    a_rst = 0; a_wrvld = 0;
    chk("a_mrst_wrrdy", 32'(a_wrrdy), 32'd1);
    chk("a_mrst_rdvld", 32'(a_rdvld), 32'd0);
    chk("a_mrst_cnt",   32'(a_cnt),   32'd0);
    chk("a_mrst_wrnf",  32'(a_wrnf),  32'd0);
    chk("a_mrst_rdne",  32'(a_rdne),  32'd1);
    a_wrvld = 1; a_wrdata = 8'h77; qa.push_back(8'h77);
    tick;
    a_wrvld = 0;
    chk("a_mrst_lat_rdvld", 32'(a_rdvld), 32'd1);
    a_rdrdy = 1; tick; a_rdrdy = 0;

    // Registered output: two-edge latency and hold under back-pressure
    b_wrvld = 1; b_wrdata = 8'hA5; qb.push_back(8'hA5);
    tick;
    b_wrvld = 0;
    chk("b_k_rdvld", 32'(b_rdvld), 32'd0);
    chk("b_k_cnt",   32'(b_cnt),   32'd1);
    tick;
    chk("b_k1_rdvld",  32'(b_rdvld),  32'd1);
    chk("b_k1_rddata", 32'(b_rddata), 32'hA5);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("b_hold_rddata", 32'(b_rddata), 32'hA5);
    end
    for (int i = 0; i < 4; i++) begin
      b_wrvld = 1; b_wrdata = 8'hB1 + 8'(i); qb.push_back(b_wrdata);
      tick;
      chk("b_fill_cnt", 32'(b_cnt), 32'(i + 2));
    end
    b_wrvld = 0;
    chk("b_full_wrrdy", 32'(b_wrrdy), 32'd0);
    chk("b_full_wrnf",  32'(b_wrnf),  32'd1);
    b_rdrdy = 1; n = 0;
    for (int i = 0; i < 20 && qb.size() > 0; i++) begin tick; n++; end
    b_rdrdy = 0;
    chk("b_drain_cycles", 32'(n), 32'd5);
    chk("b_drain_cnt",    32'(b_cnt),   32'd0);
    chk("b_drain_rdvld",  32'(b_rdvld), 32'd0);
    chk("b_drain_rdne",   32'(b_rdne),  32'd1);

    // Reset zeroes the output register
    for (int i = 0; i < 2; i++) begin
      b_wrvld = 1; b_wrdata = 8'h5A + 8'(i);
      tick;
    end
    b_wrvld = 0;
    chk("b_pre_rst_rddata", 32'(b_rddata), 32'h5A);
    chk("b_pre_rst_cnt",    32'(b_cnt),    32'd2);
    b_rst = 1; tick; b_rst = 0;
    chk("b_mrst_rddata", 32'(b_rddata), 32'd0);
    chk("b_mrst_rdvld",  32'(b_rdvld),  32'd0);
    chk("b_mrst_cnt",    32'(b_cnt),    32'd0);
    chk("b_mrst_wrrdy",  32'(b_wrrdy),  32'd1);
    chk("b_mrst_rdne",   32'(b_rdne),   32'd1);
    b_wrvld = 1; b_wrdata = 8'h77; qb.push_back(8'h77);
    tick;
    b_wrvld = 0;
    chk("b_mrst_k_rdvld", 32'(b_rdvld), 32'd0);
    tick;
    chk("b_mrst_k1_rdvld", 32'(b_rdvld), 32'd1);
    b_rdrdy = 1; tick; b_rdrdy = 0;
    chk("b_end_cnt", 32'(b_cnt), 32'd0);

    chk("a_queue_empty", 32'(qa.size()), 32'd0);
    chk("b_queue_empty", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
